vc_egress_arbiter: RTL and testbench



---
 rtl/trans_layer_pkg.sv | 18 +
 rtl/class_credit_counter.sv | 33 +++
 rtl/vc_egress_arbiter.sv | 158 +++++++++++++++
 tb/tb_vc_egress_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/trans_layer_pkg.sv
// Shared encodings for the transaction layer: layer states, class sizing, arbiter FSM states.
package trans_layer_pkg;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam int CLASS_W     = 2;
  localparam int NUM_CLASSES = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/class_credit_counter.sv
// Per-class credit: loadable 4-bit down-counter that saturates at zero.
// Load and decrement together give RELOAD-1, i.e. a fresh turn that is used immediately.
module class_credit_counter #(
  parameter logic [3:0] RELOAD = 4'd1
) (
  input  logic clk,
  input  logic reset_L,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [3:0] count_q, count_d;

  // Next credit value: reload wins, otherwise saturating decrement
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = dec_i ? (RELOAD - 4'd1) : RELOAD;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Credit register, starts each reset with a full turn
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) count_q <= RELOAD;
    else          count_q <= count_d;
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/vc_egress_arbiter.sv
// Weighted round-robin drain of the four class FIFOs into the egress FIFO.
// State | meaning
// IDLE  | nothing in flight, waiting for enable, room and a non-empty class
// ISSUE | registered pop/push of one word from active_class
// GAP   | one dead cycle so the popped FIFO's empty flag settles before the next pick
module vc_egress_arbiter
  import trans_layer_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int W0     = 4,
  parameter int W1     = 3,
  parameter int W2     = 2,
  parameter int W3     = 1
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [3:0]         state,
  input  logic               empty_0,
  input  logic               empty_1,
  input  logic               empty_2,
  input  logic               empty_3,
  input  logic [DATA_W-1:0]  data_in_0,
  input  logic [DATA_W-1:0]  data_in_1,
  input  logic [DATA_W-1:0]  data_in_2,
  input  logic [DATA_W-1:0]  data_in_3,
  input  logic               almost_full_out,
  output logic               pop_0,
  output logic               pop_1,
  output logic               pop_2,
  output logic               pop_3,
  output logic               push_out,
  output logic [DATA_W-1:0]  data_out,
  output logic [CLASS_W-1:0] active_class,
  output logic               idle
);

  localparam logic [15:0] WEIGHTS = {4'(W3), 4'(W2), 4'(W1), 4'(W0)};

  arb_state_e               fsm_q, fsm_d;
  logic [CLASS_W-1:0]       ptr_q, ptr_d, active_q, active_d;
  logic [CLASS_W-1:0]       sel, rot_sel, cand;
  logic [NUM_CLASSES-1:0]   empty_v, credit_zero, load, dec, pop_q, pop_d;
  logic [DATA_W-1:0]        data_v [NUM_CLASSES];
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     push_q, push_d, idle_q, idle_d;
  logic                     enabled, issue_ok, keep, rot_found;

  assign empty_v   = {empty_3, empty_2, empty_1, empty_0};
  assign data_v[0] = data_in_0;
  assign data_v[1] = data_in_1;
  assign data_v[2] = data_in_2;
  assign data_v[3] = data_in_3;

  assign enabled  = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign issue_ok = enabled && !almost_full_out && (empty_v != '1);

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_credit
    class_credit_counter #(.RELOAD(WEIGHTS[4*g +: 4])) u_credit (
      .clk     (clk),
      .reset_L (reset_L),
      .load_i  (load[g]),
      .dec_i   (dec[g]),
      .zero_o  (credit_zero[g])
    );
  end

  // Next non-empty class after ptr; ptr itself is tried last so a lone class keeps being served
  always_comb begin
    rot_found = 1'b0;
    rot_sel   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= NUM_CLASSES; i++) begin
      cand = ptr_q + CLASS_W'(i);
      if (!rot_found && !empty_v[cand]) begin
        rot_found = 1'b1;
        rot_sel   = cand;
      end
    end
  end

  assign keep = !credit_zero[ptr_q] && !empty_v[ptr_q];
  assign sel  = keep ? ptr_q : rot_sel;

  // FSM next state, credit control and registered-output next values
  always_comb begin
    fsm_d    = fsm_q;
    ptr_d    = ptr_q;
    load     = '0;
    dec      = '0;
    pop_d    = '0;
    push_d   = 1'b0;
    data_d   = data_q;
    active_d = active_q;
    idle_d   = idle_q;
    if (state == ST_RESET) begin
      fsm_d    = ARB_IDLE;
      ptr_d    = '0;
      load     = '1;
      data_d   = '0;
      active_d = '0;
      idle_d   = 1'b1;
    end else begin
      case (fsm_q)
        ARB_ISSUE: begin
          fsm_d  = ARB_GAP;
          idle_d = 1'b0;
        end
        default: begin
          if (issue_ok) begin
            if (!keep) begin
              load[ptr_q] = 1'b1;
              load[sel]   = 1'b1;
              ptr_d       = sel;
            end
            dec[sel]   = 1'b1;
            pop_d[sel] = 1'b1;
            push_d     = 1'b1;
            data_d     = data_v[sel];
            active_d   = sel;
            idle_d     = 1'b0;
            fsm_d      = ARB_ISSUE;
          end else begin
            fsm_d  = ARB_IDLE;
            idle_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fsm_q    <= ARB_IDLE;
      ptr_q    <= '0;
      pop_q    <= '0;
      push_q   <= 1'b0;
      data_q   <= '0;
      active_q <= '0;
      idle_q   <= 1'b1;
    end else begin
      fsm_q    <= fsm_d;
      ptr_q    <= ptr_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      data_q   <= data_d;
      active_q <= active_d;
      idle_q   <= idle_d;
    end
  end

  assign {pop_3, pop_2, pop_1, pop_0} = pop_q;
  assign push_out     = push_q;
  assign data_out     = data_q;
  assign active_class = active_q;
  assign idle         = idle_q;

endmodule

// File: tb/tb_vc_egress_arbiter.sv
// Bench for vc_egress_arbiter: FIFO models feed the DUT, expected pops go into a scoreboard queue.
module tb_vc_egress_arbiter;
  import trans_layer_pkg::*;

  typedef struct {
    logic [1:0]  cls;
    logic [11:0] data;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] st;
    int         n0, n1, n2, n3;
    string      seq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        almost_full_out = 1'b0;
  logic [3:0]  state = ST_RESET;
  logic [3:0]  empty_v = 4'hF;
  logic [11:0] din [4];
  logic        pop_0, pop_1, pop_2, pop_3, push_out, idle;
  logic [11:0] data_out;
  logic [1:0]  active_class;

  logic [11:0] fq [4][$];
  exp_t        exp_q [$];
  int          cnt [4];
  int          n_total = 0;
  int          n_pass = 0;
  int          push_cnt = 0;
  logic        prev_push = 1'b0;
  vec_t        vecs [7];

  always #5 clk = ~clk;

  vc_egress_arbiter dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .state           (state),
    .empty_0         (empty_v[0]),
    .empty_1         (empty_v[1]),
    .empty_2         (empty_v[2]),
    .empty_3         (empty_v[3]),
    .data_in_0       (din[0]),
    .data_in_1       (din[1]),
    .data_in_2       (din[2]),
    .data_in_3       (din[3]),
    .almost_full_out (almost_full_out),
    .pop_0           (pop_0),
    .pop_1           (pop_1),
    .pop_2           (pop_2),
    .pop_3           (pop_3),
    .push_out        (push_out),
    .data_out        (data_out),
    .active_class    (active_class),
    .idle            (idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic update_flags();
    for (int c = 0; c < 4; c++) begin
      empty_v[c] = (fq[c].size() == 0);
      din[c]     = (fq[c].size() > 0) ? fq[c][0] : 12'h000;
    end
  endtask

  // One cycle: wait for the falling edge, score any push, retire the popped word from the model
  task automatic tick();
    logic [3:0] pv;
    exp_t       e;
    @(negedge clk);
    pv = {pop_3, pop_2, pop_1, pop_0};
    if (push_out) begin
      push_cnt++;
      check("one_word_per_two_cycles", {31'b0, prev_push}, 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_push: got class %0d data %03h, expected no push", active_class, data_out);
      end else begin
        e = exp_q.pop_front();
        check("pop_onehot", {28'b0, pv}, 32'd1 << e.cls);
        check("data_out", {20'b0, data_out}, {20'b0, e.data});
        check("active_class", {30'b0, active_class}, {30'b0, e.cls});
      end
      for (int c = 0; c < 4; c++)
        if (pv[c] && fq[c].size() > 0) fq[c].delete(0);
      update_flags();
    end else begin
      check("no_pop_without_push", {28'b0, pv}, 32'd0);
    end
    prev_push = push_out;
  endtask

  task automatic do_reset(input logic [3:0] st);
    reset_L = 1'b0;
    almost_full_out = 1'b0;
    state = st;
    for (int c = 0; c < 4; c++) begin
      fq[c].delete();
      cnt[c] = 0;
    end
    exp_q.delete();
    update_flags();
    prev_push = 1'b0;
    tick();
  endtask

  task automatic fill(input int c, input int n);
    for (int j = 0; j < n; j++) fq[c].push_back({2'(c), 10'(j)});
    update_flags();
  endtask

  task automatic expect_str(input string s);
    int c;
    for (int i = 0; i < s.len(); i++) begin
      c = int'(s[i]) - 48;
      exp_q.push_back('{cls: 2'(c), data: {2'(c), 10'(cnt[c])}});
      cnt[c]++;
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    repeat (4) tick();
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_idle"}, {31'b0, idle}, 32'd1);
  endtask

  task automatic wait_pushes(input string name, input int base, input int n);
    for (int i = 0; i < 50 && push_cnt < base + n; i++) tick();
    check({name, "_push_count"}, push_cnt - base, n);
  endtask

  initial begin
    int base, left;

    vecs[0] = '{"all_full",   ST_ACTIVE, 8, 6, 4, 2, "00001112230000111223"};
    vecs[1] = '{"skip_1_3",   ST_IDLE,   0, 1, 0, 2, "133"};
    vecs[2] = '{"only_2",     ST_ACTIVE, 0, 0, 3, 0, "222"};
    vecs[3] = '{"c0_empties", ST_IDLE,   1, 2, 0, 0, "011"};
    vecs[4] = '{"c0_c3",      ST_ACTIVE, 5, 0, 0, 2, "0000303"};
    vecs[5] = '{"init_gate",  ST_INIT,   2, 2, 2, 2, ""};
    vecs[6] = '{"reset_gate", ST_RESET,  2, 2, 2, 2, ""};

    for (int v = 0; v < 7; v++) begin
      do_reset(vecs[v].st);
      fill(0, vecs[v].n0); fill(1, vecs[v].n1); fill(2, vecs[v].n2); fill(3, vecs[v].n3);
      expect_str(vecs[v].seq);
      tick();
      check("rst_push", {31'b0, push_out}, 32'd0);
      check("rst_idle", {31'b0, idle}, 32'd1);
      check("rst_data", {20'b0, data_out}, 32'd0);
      check("rst_active", {30'b0, active_class}, 32'd0);
      reset_L = 1'b1;
      tick();
      check({vecs[v].name, "_first_issue"}, {31'b0, push_out}, {31'b0, vecs[v].seq.len() > 0});
      drain(vecs[v].name, 100);
      left = vecs[v].n0 + vecs[v].n1 + vecs[v].n2 + vecs[v].n3 - vecs[v].seq.len();
      check({vecs[v].name, "_leftover"}, fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size(), left);
    end

    // Backpressure raised in the gap after the second pop; class 0 resumes with two credits
    do_reset(ST_ACTIVE);
    fill(0, 4); fill(1, 3); fill(2, 2); fill(3, 1);
    expect_str("00");
    base = push_cnt;
    reset_L = 1'b1;
    wait_pushes("bp_pre", base, 2);
    @(posedge clk);
    #1 almost_full_out = 1'b1;
    repeat (6) tick();
    check("bp_stalled", push_cnt - base, 32'd2);
    check("bp_idle", {31'b0, idle}, 32'd1);
    expect_str("00111223");
    almost_full_out = 1'b0;
    tick();
    check("bp_resume_latency", {31'b0, push_out}, 32'd1);
    drain("bp", 100);

    // Layer state drops to RESET during an ISSUE; pointer and credits restart from scratch
    do_reset(ST_ACTIVE);
    fill(0, 7); fill(1, 3); fill(2, 2); fill(3, 1);
    expect_str("000");
    base = push_cnt;
    reset_L = 1'b1;
    wait_pushes("abort_pre", base, 3);
    state = ST_RESET;
    tick();
    check("abort_push", {31'b0, push_out}, 32'd0);
    check("abort_idle", {31'b0, idle}, 32'd1);
    check("abort_active", {30'b0, active_class}, 32'd0);
    check("abort_data", {20'b0, data_out}, 32'd0);
    repeat (4) tick();
    check("abort_hold", push_cnt - base, 32'd3);
    expect_str("0000111223");
    state = ST_IDLE;
    drain("abort", 100);

    // Data path: word from class 2 shows up with its pop
    do_reset(ST_ACTIVE);
    fq[2].push_back(12'hA5C);
    update_flags();
    exp_q.push_back('{cls: 2'd2, data: 12'hA5C});
    reset_L = 1'b1;
    tick();
    check("dp_push", {31'b0, push_out}, 32'd1);
    check("dp_pop2", {31'b0, pop_2}, 32'd1);
    drain("dp", 20);

    // Asynchronous reset in the middle of an ISSUE clears outputs without a clock edge
    do_reset(ST_ACTIVE);
    fill(0, 4);
    expect_str("0");
    reset_L = 1'b1;
    tick();
    @(posedge clk);
    @(posedge clk);
    #2;
    check("async_pre_push", {31'b0, push_out}, 32'd1);
    reset_L = 1'b0;
    #1;
    check("async_push", {31'b0, push_out}, 32'd0);
    check("async_pop0", {31'b0, pop_0}, 32'd0);
    check("async_idle", {31'b0, idle}, 32'd1);
    check("async_data", {20'b0, data_out}, 32'd0);
    do_reset(ST_RESET);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
